// File: rtl/bus_main_arb.sv
// rtl/bus_main_arb.sv - bmain bus arbiter between fe1 fetch engine and mem1 data stage
module bus_main_arb #(
  parameter bit RST_PRIO_MEM1 = 1'b1
) (
  input  logic        clk_core,
  input  logic        reset_n,
  input  logic        fe1_cvalid,
  input  logic [28:2] fe1_addr,
  input  logic        fe1_rready,
  input  logic        fe1_eack,
  output logic        bmain_cready_fe1,
  output logic        bmain_rvalid_fe1,
  output logic        bmain_error_fe1,
  input  logic        mem1_cvalid,
  input  logic        mem1_cmd,
  input  logic [28:2] mem1_addr,
  input  logic        mem1_rready,
  input  logic        mem1_wvalid,
  input  logic        mem1_wlast,
  input  logic [31:0] mem1_wdata,
  input  logic [3:0]  mem1_wmask,
  input  logic        mem1_eack,
  output logic        bmain_cready_mem1,
  output logic        bmain_rvalid_mem1,
  output logic        bmain_wready_mem1,
  output logic        bmain_error_mem1,
  output logic        bus_cvalid,
  output logic        bus_cmd,
  output logic [28:2] bus_addr,
  input  logic        bus_cready,
  input  logic        bus_rvalid,
  input  logic        bus_rlast,
  output logic        bus_rready,
  output logic        bus_wvalid,
  output logic        bus_wlast,
  output logic [31:0] bus_wdata,
  output logic [3:0]  bus_wmask,
  input  logic        bus_wready,
  input  logic        bus_error,
  output logic        bus_eack
);

  typedef enum logic [1:0] {IDLE, CMD, READ, WRITE} state_t;

  state_t state_q, state_d;
  logic   owner_q, owner_d;  // 1 = mem1, 0 = fe1
  logic   prio_q, prio_d;    // 1 = mem1 wins a tie

  logic grant_mem1, cur_owner, cmd_phase, cmd_hs;
  logic err_phase, err_done, r_route, w_route, rd_done, wr_done;

  always_ff @(posedge clk_core or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      owner_q <= 1'b0;
      prio_q  <= RST_PRIO_MEM1;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      prio_q  <= prio_d;
    end
  end

  always_comb begin
    state_d           = state_q;
    owner_d           = owner_q;
    prio_d            = prio_q;
    grant_mem1        = mem1_cvalid & (prio_q | ~fe1_cvalid);
    cur_owner         = (state_q == IDLE) ? grant_mem1 : owner_q;
    cmd_phase         = 1'b0;
    cmd_hs            = 1'b0;
    err_phase         = 1'b0;
    err_done          = 1'b0;
    r_route           = 1'b0;
    w_route           = 1'b0;
    rd_done           = 1'b0;
    wr_done           = 1'b0;
    bmain_cready_fe1  = 1'b0;
    bmain_rvalid_fe1  = 1'b0;
    bmain_error_fe1   = 1'b0;
    bmain_cready_mem1 = 1'b0;
    bmain_rvalid_mem1 = 1'b0;
    bmain_wready_mem1 = 1'b0;
    bmain_error_mem1  = 1'b0;
    bus_cvalid        = 1'b0;
    bus_cmd           = 1'b0;
    bus_addr          = '0;
    bus_rready        = 1'b0;
    bus_wvalid        = 1'b0;
    bus_wlast         = 1'b0;
    bus_wdata         = '0;
    bus_wmask         = '0;
    bus_eack          = 1'b0;

    // Outputs are gated by reset_n so they drop without waiting for a clock.
    if (reset_n) begin
      cmd_phase = ((state_q == IDLE) && (fe1_cvalid || mem1_cvalid)) || (state_q == CMD);
      if (cmd_phase) begin
        bus_cvalid        = cur_owner ? mem1_cvalid : fe1_cvalid;
        bus_cmd           = cur_owner ? mem1_cmd : 1'b1;
        bus_addr          = cur_owner ? mem1_addr : fe1_addr;
        bmain_cready_mem1 = cur_owner & bus_cready;
        bmain_cready_fe1  = ~cur_owner & bus_cready;
      end
      cmd_hs = bus_cvalid & bus_cready;

      err_phase = (state_q != IDLE);
      if (err_phase) begin
        bus_eack         = owner_q ? mem1_eack : fe1_eack;
        bmain_error_mem1 = owner_q & bus_error;
        bmain_error_fe1  = ~owner_q & bus_error;
      end
      err_done = err_phase & bus_error & bus_eack;

      // A write beat may ride along with the command handshake.
      r_route = (state_q == READ) & ~err_done;
      w_route = ((state_q == WRITE) | (cmd_hs & cur_owner & ~mem1_cmd)) & ~err_done;
      if (r_route) begin
        bus_rready        = owner_q ? mem1_rready : fe1_rready;
        bmain_rvalid_mem1 = owner_q & bus_rvalid;
        bmain_rvalid_fe1  = ~owner_q & bus_rvalid;
      end
      if (w_route) begin
        bus_wvalid        = mem1_wvalid;
        bus_wlast         = mem1_wlast;
        bus_wdata         = mem1_wdata;
        bus_wmask         = mem1_wmask;
        bmain_wready_mem1 = bus_wready;
      end
      rd_done = bus_rvalid & bus_rready & bus_rlast;
      wr_done = bus_wvalid & bus_wready & bus_wlast;

      case (state_q)
        IDLE, CMD: begin
          if (err_done) begin
            state_d = IDLE;
            prio_d  = ~owner_q;
          end else if (cmd_phase) begin
            owner_d = cur_owner;
            if (!cmd_hs) begin
              state_d = CMD;
            end else if (bus_cmd) begin
              state_d = READ;
            end else if (wr_done) begin
              state_d = IDLE;
              prio_d  = 1'b0;
            end else begin
              state_d = WRITE;
            end
          end
        end
        READ: begin
          if (err_done || rd_done) begin
            state_d = IDLE;
            prio_d  = ~owner_q;
          end
        end
        WRITE: begin
          if (err_done || wr_done) begin
            state_d = IDLE;
            prio_d  = ~owner_q;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bus_main_arb.sv
// tb/tb_bus_main_arb.sv - directed testbench for bus_main_arb
module tb_bus_main_arb;

  logic        clk_core = 1'b0;
  logic        reset_n;
  logic        fe1_cvalid, fe1_rready, fe1_eack;
  logic [28:2] fe1_addr;
  logic        bmain_cready_fe1, bmain_rvalid_fe1, bmain_error_fe1;
  logic        mem1_cvalid, mem1_cmd, mem1_rready, mem1_wvalid, mem1_wlast, mem1_eack;
  logic [28:2] mem1_addr;
  logic [31:0] mem1_wdata;
  logic [3:0]  mem1_wmask;
  logic        bmain_cready_mem1, bmain_rvalid_mem1, bmain_wready_mem1, bmain_error_mem1;
  logic        bus_cvalid, bus_cmd, bus_cready, bus_rvalid, bus_rlast, bus_rready;
  logic [28:2] bus_addr;
  logic        bus_wvalid, bus_wlast, bus_wready, bus_error, bus_eack;
  logic [31:0] bus_wdata;
  logic [3:0]  bus_wmask;
  logic [75:0] all_out;

  int n_assert = 0;
  int n_fail   = 0;
  int k;
  int obs_beats;
  logic wr_pat [5];

  localparam logic [28:2] A_FE  = 27'h1234567;
  localparam logic [28:2] A_MEM = 27'h2ABCDEF;

  always #5 clk_core = ~clk_core;

  bus_main_arb #(.RST_PRIO_MEM1(1'b1)) dut (
    .clk_core(clk_core), .reset_n(reset_n),
    .fe1_cvalid(fe1_cvalid), .fe1_addr(fe1_addr), .fe1_rready(fe1_rready), .fe1_eack(fe1_eack),
    .bmain_cready_fe1(bmain_cready_fe1), .bmain_rvalid_fe1(bmain_rvalid_fe1),
    .bmain_error_fe1(bmain_error_fe1),
    .mem1_cvalid(mem1_cvalid), .mem1_cmd(mem1_cmd), .mem1_addr(mem1_addr),
    .mem1_rready(mem1_rready), .mem1_wvalid(mem1_wvalid), .mem1_wlast(mem1_wlast),
    .mem1_wdata(mem1_wdata), .mem1_wmask(mem1_wmask), .mem1_eack(mem1_eack),
    .bmain_cready_mem1(bmain_cready_mem1), .bmain_rvalid_mem1(bmain_rvalid_mem1),
    .bmain_wready_mem1(bmain_wready_mem1), .bmain_error_mem1(bmain_error_mem1),
    .bus_cvalid(bus_cvalid), .bus_cmd(bus_cmd), .bus_addr(bus_addr), .bus_cready(bus_cready),
    .bus_rvalid(bus_rvalid), .bus_rlast(bus_rlast), .bus_rready(bus_rready),
    .bus_wvalid(bus_wvalid), .bus_wlast(bus_wlast), .bus_wdata(bus_wdata),
    .bus_wmask(bus_wmask), .bus_wready(bus_wready), .bus_error(bus_error), .bus_eack(bus_eack)
  );

  assign all_out = {bmain_cready_fe1, bmain_rvalid_fe1, bmain_error_fe1, bmain_cready_mem1,
                    bmain_rvalid_mem1, bmain_wready_mem1, bmain_error_mem1, bus_cvalid, bus_cmd,
                    bus_addr, bus_rready, bus_wvalid, bus_wlast, bus_wdata, bus_wmask, bus_eack};

  task automatic chk1(input string tag, input logic obs, input logic exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
    end
  endtask

  task automatic chkw(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clr_inputs;
    fe1_cvalid = 1'b0; fe1_addr = '0; fe1_rready = 1'b0; fe1_eack = 1'b0;
    mem1_cvalid = 1'b0; mem1_cmd = 1'b0; mem1_addr = '0; mem1_rready = 1'b0;
    mem1_wvalid = 1'b0; mem1_wlast = 1'b0; mem1_wdata = '0; mem1_wmask = '0; mem1_eack = 1'b0;
    bus_cready = 1'b0; bus_rvalid = 1'b0; bus_rlast = 1'b0; bus_wready = 1'b0; bus_error = 1'b0;
  endtask

  task automatic tick;
    @(posedge clk_core);
    #1;
  endtask

  task automatic do_reset;
    reset_n = 1'b0;
    clr_inputs();
    #1;
    chkw("reset_outs", 128'(all_out), 128'(0));
    tick();
    reset_n = 1'b1;
  endtask

  // Non-destructive: both request with bus_cready=0 and are withdrawn before the edge.
  task automatic probe_prio(input logic exp_mem1, input string tag);
    fe1_cvalid = 1'b1; fe1_addr = A_FE;
    mem1_cvalid = 1'b1; mem1_addr = A_MEM; mem1_cmd = 1'b1;
    bus_cready = 1'b0;
    #1;
    chkw(tag, 128'(bus_addr), exp_mem1 ? 128'(A_MEM) : 128'(A_FE));
    clr_inputs();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    wr_pat = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
    reset_n = 1'b0;
    clr_inputs();
    tick();

    // Single fe1 read, 4 beats
    do_reset();
    fe1_cvalid = 1'b1; fe1_addr = A_FE; bus_cready = 1'b1;
    #1;
    chk1("t1_cvalid", bus_cvalid, 1'b1);
    chk1("t1_cmd", bus_cmd, 1'b1);
    chkw("t1_addr", 128'(bus_addr), 128'(A_FE));
    chk1("t1_cready_fe1", bmain_cready_fe1, 1'b1);
    chk1("t1_cready_mem1", bmain_cready_mem1, 1'b0);
    tick();
    fe1_cvalid = 1'b0; bus_cready = 1'b0; fe1_rready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      bus_rvalid = 1'b1; bus_rlast = (i == 3);
      #1;
      chk1("t1_rvalid_fe1", bmain_rvalid_fe1, 1'b1);
      chk1("t1_rvalid_mem1", bmain_rvalid_mem1, 1'b0);
      chk1("t1_rready", bus_rready, 1'b1);
      tick();
    end
    clr_inputs();
    #1;
    chkw("t1_idle", 128'(all_out), 128'(0));
    probe_prio(1'b1, "t1_prio");

    // Simultaneous request after reset
    do_reset();
    fe1_cvalid = 1'b1; fe1_addr = A_FE;
    mem1_cvalid = 1'b1; mem1_cmd = 1'b1; mem1_addr = A_MEM; bus_cready = 1'b1;
    #1;
    chkw("t2_addr_mem1", 128'(bus_addr), 128'(A_MEM));
    chk1("t2_cready_mem1", bmain_cready_mem1, 1'b1);
    chk1("t2_cready_fe1", bmain_cready_fe1, 1'b0);
    tick();
    mem1_cvalid = 1'b0; mem1_rready = 1'b1;
    for (int i = 0; i < 2; i++) begin
      bus_rvalid = 1'b1; bus_rlast = (i == 1);
      #1;
      chk1("t2_fe1_waits", bmain_cready_fe1, 1'b0);
      chk1("t2_no_cvalid", bus_cvalid, 1'b0);
      chk1("t2_rvalid_mem1", bmain_rvalid_mem1, 1'b1);
      tick();
    end
    bus_rvalid = 1'b0; bus_rlast = 1'b0; mem1_rready = 1'b0;
    #1;
    chk1("t2_fe1_granted", bmain_cready_fe1, 1'b1);
    chkw("t2_addr_fe1", 128'(bus_addr), 128'(A_FE));
    tick();
    fe1_cvalid = 1'b0; fe1_rready = 1'b1; bus_rvalid = 1'b1; bus_rlast = 1'b1;
    #1;
    chk1("t2_rvalid_fe1", bmain_rvalid_fe1, 1'b1);
    tick();
    clr_inputs();

    // mem1 write with wready 1,0,1,1,1
    do_reset();
    mem1_cvalid = 1'b1; mem1_cmd = 1'b0; mem1_addr = A_MEM; bus_cready = 1'b1;
    mem1_wvalid = 1'b1;
    k = 0;
    obs_beats = 0;
    for (int c = 0; c < 5; c++) begin
      bus_wready = wr_pat[c];
      mem1_wdata = 32'hA000_0000 + 32'(k);
      mem1_wmask = 4'(k + 1);
      mem1_wlast = (k == 3);
      #1;
      if (c == 0) chk1("t3_cmd", bus_cmd, 1'b0);
      chk1("t3_wvalid", bus_wvalid, 1'b1);
      chkw("t3_wdata", 128'(bus_wdata), 128'(32'hA000_0000 + 32'(k)));
      chkw("t3_wmask", 128'(bus_wmask), 128'(4'(k + 1)));
      chk1("t3_wready", bmain_wready_mem1, wr_pat[c]);
      chk1("t3_wlast", bus_wlast, (k == 3));
      if (bus_wvalid && bmain_wready_mem1) obs_beats++;
      if (wr_pat[c]) k++;
      tick();
      mem1_cvalid = 1'b0; bus_cready = 1'b0;
    end
    chkw("t3_beats", 128'(obs_beats), 128'(4));
    mem1_wvalid = 1'b1; mem1_wlast = 1'b0; bus_wready = 1'b1;
    #1;
    chk1("t3_idle_wvalid", bus_wvalid, 1'b0);
    chk1("t3_idle_wready", bmain_wready_mem1, 1'b0);
    clr_inputs();
    probe_prio(1'b0, "t3_prio");

    // Pending fe1 command holds grant while mem1 joins
    do_reset();
    fe1_cvalid = 1'b1; fe1_addr = A_FE; mem1_addr = A_MEM; mem1_cmd = 1'b1; bus_cready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      if (c == 1) mem1_cvalid = 1'b1;
      #1;
      chkw("t4_addr_hold", 128'(bus_addr), 128'(A_FE));
      chk1("t4_cvalid", bus_cvalid, 1'b1);
      chk1("t4_cready_mem1", bmain_cready_mem1, 1'b0);
      tick();
    end
    bus_cready = 1'b1;
    #1;
    chk1("t4_hs_fe1", bmain_cready_fe1, 1'b1);
    chk1("t4_hs_mem1", bmain_cready_mem1, 1'b0);
    chkw("t4_hs_addr", 128'(bus_addr), 128'(A_FE));
    tick();
    fe1_cvalid = 1'b0; fe1_rready = 1'b1; bus_rvalid = 1'b1; bus_rlast = 1'b1;
    #1;
    chk1("t4_rvalid_fe1", bmain_rvalid_fe1, 1'b1);
    chk1("t4_mem1_blocked", bmain_cready_mem1, 1'b0);
    tick();
    bus_rvalid = 1'b0; bus_rlast = 1'b0; fe1_rready = 1'b0;
    #1;
    chk1("t4_mem1_next", bmain_cready_mem1, 1'b1);
    chkw("t4_mem1_addr", 128'(bus_addr), 128'(A_MEM));
    clr_inputs();

    // Bus error during mem1 read beat 2
    do_reset();
    mem1_cvalid = 1'b1; mem1_cmd = 1'b1; mem1_addr = A_MEM; bus_cready = 1'b1;
    #1;
    chk1("t5_cready_mem1", bmain_cready_mem1, 1'b1);
    tick();
    mem1_cvalid = 1'b0; bus_cready = 1'b0; mem1_rready = 1'b1; bus_rvalid = 1'b1;
    #1;
    chk1("t5_beat1", bmain_rvalid_mem1, 1'b1);
    tick();
    bus_rvalid = 1'b0; bus_error = 1'b1;
    #1;
    chk1("t5_err_mem1", bmain_error_mem1, 1'b1);
    chk1("t5_err_fe1", bmain_error_fe1, 1'b0);
    chk1("t5_eack_low", bus_eack, 1'b0);
    tick();
    mem1_eack = 1'b1;
    #1;
    chk1("t5_eack", bus_eack, 1'b1);
    chk1("t5_err_hold", bmain_error_mem1, 1'b1);
    tick();
    #1;
    chkw("t5_idle_err", 128'(all_out), 128'(0));
    clr_inputs();
    probe_prio(1'b0, "t5_prio");

    // Asynchronous reset mid-READ
    do_reset();
    mem1_cvalid = 1'b1; mem1_cmd = 1'b1; mem1_addr = A_MEM; bus_cready = 1'b1;
    tick();
    mem1_cvalid = 1'b0; fe1_cvalid = 1'b1; fe1_addr = A_FE;
    mem1_rready = 1'b1; bus_rvalid = 1'b1;
    #1;
    chk1("t6_in_read", bmain_rvalid_mem1, 1'b1);
    #1;
    reset_n = 1'b0;
    #1;
    chkw("t6_async", 128'(all_out), 128'(0));
    tick();
    reset_n = 1'b1;
    clr_inputs();
    #1;
    chkw("t6_idle", 128'(all_out), 128'(0));
    probe_prio(1'b1, "t6_prio");
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/bus_main_arb.md
Name: bus_main_arb

Overview:
- Shares the single bmain bus master port between two requesters: the instruction-fetch miss/fill engine (fe1) and the data-memory stage (mem1).
- Arbitrates command issue and locks the bus to the winner until its burst completes, by last read beat, last write beat or error.
- Routes the per-master cready, rvalid, wready and error strobes.
- rdata and rlast are broadcast to both masters by the top level and do not pass through this block.

Parameters:
- RST_PRIO_MEM1, 1, master that holds priority after reset (1 = mem1, 0 = fe1).

Ports:
- clk_core  in  1  core clock.
- reset_n  in  1  reset. One clock; reset is asynchronous and active-low.
- fe1_cvalid  in  1  fe1 command valid.
- fe1_addr  in  27  fe1 word address [28:2].
- fe1_rready  in  1  fe1 ready for read beat.
- fe1_eack  in  1  fe1 error acknowledge.
- bmain_cready_fe1  out  1  command accepted for fe1.
- bmain_rvalid_fe1  out  1  read beat valid for fe1.
- bmain_error_fe1  out  1  bus error for fe1.
- mem1_cvalid  in  1  mem1 command valid.
- mem1_cmd  in  1  1 = read, 0 = write.
- mem1_addr  in  27  mem1 word address [28:2].
- mem1_rready  in  1  mem1 ready for read beat.
- mem1_wvalid  in  1  mem1 write beat valid.
- mem1_wlast  in  1  last write beat.
- mem1_wdata  in  32  write data.
- mem1_wmask  in  4  byte enables.
- mem1_eack  in  1  mem1 error acknowledge.
- bmain_cready_mem1  out  1  command accepted for mem1.
- bmain_rvalid_mem1  out  1  read beat valid for mem1.
- bmain_wready_mem1  out  1  write beat accepted for mem1.
- bmain_error_mem1  out  1  bus error for mem1.
- bus_cvalid / bus_cmd / bus_addr[28:2]  out  1/1/27  command to the bus.
- bus_cready  in  1  bus accepts command.
- bus_rvalid  in  1  bus read beat valid.
- bus_rlast  in  1  last read beat.
- bus_rready  out  1  muxed read ready.
- bus_wvalid / bus_wlast / bus_wdata / bus_wmask  out  1/1/32/4  write beat.
- bus_wready  in  1  bus accepts write beat.
- bus_error  in  1  bus error.
- bus_eack  out  1  muxed error acknowledge.

Behaviour:
- State machine: IDLE, CMD, READ, WRITE. Also holds an owner register (fe1/mem1) and a priority register prio.
- Reset: async on reset_n low. State goes to IDLE and prio to RST_PRIO_MEM1. All bus_* and bmain_* outputs are 0.
- fe1 is read-only. fe1 has no cmd port, and bus_cmd is forced to 1 when fe1 owns the bus.
- IDLE, no request: all outputs stay 0.
- IDLE, exactly one cvalid: that master is granted combinationally. Its cvalid/cmd/addr are forwarded to bus_* in the same cycle, and bus_cready is reflected on its bmain_cready_*.
- IDLE, both cvalid: the prio master wins.
- IDLE, grant made, bus_cready=0: owner is latched and the next state is CMD. The grant must not change while a command is pending, even if the other master requests.
- CMD: keeps forwarding the owner's command until bus_cready.
- Command handshake (bus_cvalid & bus_cready) in IDLE or CMD: next state is READ if cmd=1, else WRITE. Owner is latched if the handshake happens in IDLE.
- READ:
  - bus_rready = owner rready.
  - bmain_rvalid_<owner> = bus_rvalid; the other master's rvalid stays 0.
  - On bus_rvalid & bus_rready & bus_rlast: go to IDLE and set prio to the non-owner.
- WRITE (mem1 only):
  - bus_w* = mem1_w*, and bmain_wready_mem1 = bus_wready.
  - bus_wvalid may be asserted in the same cycle as the command handshake; that beat is routed.
  - On bus_wvalid & bus_wready & bus_wlast: go to IDLE and set prio to fe1.
- Error:
  - In CMD/READ/WRITE, bus_error is routed to bmain_error_<owner> and bus_eack = owner eack.
  - On bus_error & bus_eack: go to IDLE and set prio to the non-owner. No further beats are routed.
  - bus_error in IDLE is not routed and bus_eack = 0.
- Non-owner strobes: the non-owner's cready, rvalid, wready and error are always 0 outside IDLE arbitration.
- Back-to-back: a new arbitration can occur in the cycle after the return to IDLE. Minimum spacing is one IDLE cycle between bursts.
- Fairness: priority alternates, so neither master waits more than one foreign burst once it requests.

Test Plan:
- Single fe1 read, bus_cready=1 in first cycle, 4 beats with rlast on the 4th:
  - bus_cmd=1 and bus_addr=fe1_addr.
  - bmain_rvalid_fe1 pulses 4 times and bmain_rvalid_mem1 stays 0.
  - IDLE after the 4th beat, prio=mem1.
- Both request in the same cycle after reset:
  - mem1 is granted first.
  - fe1's cready stays 0 until mem1's burst ends.
  - fe1 is granted in the first IDLE cycle after mem1's burst.
- mem1 write, 4 beats with bus_wready toggling 1,0,1,1,1:
  - exactly 4 beats complete and bus_wlast passes through on the 4th.
  - return to IDLE after the 4th beat, prio=fe1.
- fe1 cvalid held with bus_cready=0 for 3 cycles, and mem1 raises cvalid in cycle 2:
  - grant stays fe1 and bus_addr is stable.
  - fe1 wins on handshake.
- bus_error during mem1 read beat 2:
  - bmain_error_mem1=1 and bmain_error_fe1=0.
  - mem1_eack is routed to bus_eack.
  - IDLE next cycle, prio=fe1.
- reset_n low mid-READ:
  - all outputs 0 immediately, without waiting for a clock edge.
  - after release, state is IDLE and prio follows RST_PRIO_MEM1.
